// File: rtl/issue_scoreboard.sv
// Issue-stage controller: holds one decoded instruction in a registered slot,
// tracks outstanding register writes in a pending scoreboard, and stalls
// decode on RAW/WAW hazards, slot backpressure or the in-flight write limit.
module issue_scoreboard #(
   parameter int MAX_INFLIGHT = 4,
   parameter int CNT_W        = 16,
   localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dec_valid,
   output logic             dec_ready,
   input  logic [4:0]       dec_rd,
   input  logic [4:0]       dec_rs1,
   input  logic [4:0]       dec_rs2,
   input  logic             dec_use_rs1,
   input  logic             dec_use_rs2,
   input  logic             dec_use_imm,
   input  logic             dec_wb_we,
   input  logic [3:0]       dec_alu_op,
   input  logic [31:0]      dec_imm,
   output logic             iss_valid,
   input  logic             iss_ready,
   output logic [4:0]       iss_rd,
   output logic [4:0]       iss_rs1,
   output logic [4:0]       iss_rs2,
   output logic             iss_use_rs1,
   output logic             iss_use_rs2,
   output logic             iss_use_imm,
   output logic             iss_wb_we,
   output logic [3:0]       iss_alu_op,
   output logic [31:0]      iss_imm,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   output logic [IW-1:0]    inflight,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             wb_err
);

   logic [31:0]   pend;
   logic [31:0]   wbmask;
   logic [31:0]   pend_eff;
   logic          wb_hit;
   logic          wb_miss;
   logic [IW-1:0] cnt_after;
   logic          hazard;
   logic          accept;
   logic          inc;

   // Hazard detection with same-cycle writeback bypass, plus the decode handshake
   always_comb begin
      wbmask = '0;
      if (wb_valid) begin
         wbmask[wb_rd] = 1'b1;
      end
      pend_eff  = pend & ~wbmask;
      wb_hit    = wb_valid && (wb_rd != 5'd0) && pend[wb_rd];
      wb_miss   = wb_valid && (wb_rd != 5'd0) && !pend[wb_rd];
      cnt_after = inflight - IW'(wb_hit);
      hazard    = 1'b0;
      if (dec_use_rs1 && pend_eff[dec_rs1]) begin
         hazard = 1'b1;
      end
      if (dec_use_rs2 && pend_eff[dec_rs2]) begin
         hazard = 1'b1;
      end
      if (dec_wb_we && (dec_rd != 5'd0) && pend_eff[dec_rd]) begin
         hazard = 1'b1;
      end
      if (dec_wb_we && (dec_rd != 5'd0) && (cnt_after == IW'(MAX_INFLIGHT))) begin
         hazard = 1'b1;
      end
      dec_ready = !rst && !hazard && (!iss_valid || iss_ready);
      accept    = dec_valid && dec_ready;
      inc       = accept && dec_wb_we && (dec_rd != 5'd0);
   end

   // Pending scoreboard: writeback clears first so a same-cycle set wins
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= '0;
      end else begin
         if (wb_hit) begin
            pend[wb_rd] <= 1'b0;
         end
         if (inc) begin
            pend[dec_rd] <= 1'b1;
         end
      end
   end

   // Outstanding write counter; simultaneous issue and retire cancel out
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= '0;
      end else if (inc && !wb_hit) begin
         inflight <= inflight + IW'(1);
      end else if (!inc && wb_hit) begin
         inflight <= inflight - IW'(1);
      end
   end

   // Saturating count of cycles where decode offered an instruction but was stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (dec_valid && !dec_ready && (stall_cycles != {CNT_W{1'b1}})) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

   // Sticky error for a writeback to a register that was never marked pending
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_err <= 1'b0;
      end else if (wb_miss) begin
         wb_err <= 1'b1;
      end
   end

   // Issue slot: load on accept, drain when execute consumes it, otherwise hold
   always_ff @(posedge clk) begin
      if (rst) begin
         iss_valid   <= 1'b0;
         iss_rd      <= '0;
         iss_rs1     <= '0;
         iss_rs2     <= '0;
         iss_use_rs1 <= 1'b0;
         iss_use_rs2 <= 1'b0;
         iss_use_imm <= 1'b0;
         iss_wb_we   <= 1'b0;
         iss_alu_op  <= '0;
         iss_imm     <= '0;
      end else if (accept) begin
         iss_valid   <= 1'b1;
         iss_rd      <= dec_rd;
         iss_rs1     <= dec_rs1;
         iss_rs2     <= dec_rs2;
         iss_use_rs1 <= dec_use_rs1;
         iss_use_rs2 <= dec_use_rs2;
         iss_use_imm <= dec_use_imm;
         iss_wb_we   <= dec_wb_we;
         iss_alu_op  <= dec_alu_op;
         iss_imm     <= dec_imm;
      end else if (iss_ready && iss_valid) begin
         iss_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard (MAX_INFLIGHT=4, CNT_W=16).
module tb_issue_scoreboard;

   logic        clk;
   logic        rst;
   logic        dec_valid;
   logic        dec_ready;
   logic [4:0]  dec_rd;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic        dec_use_rs1;
   logic        dec_use_rs2;
   logic        dec_use_imm;
   logic        dec_wb_we;
   logic [3:0]  dec_alu_op;
   logic [31:0] dec_imm;
   logic        iss_valid;
   logic        iss_ready;
   logic [4:0]  iss_rd;
   logic [4:0]  iss_rs1;
   logic [4:0]  iss_rs2;
   logic        iss_use_rs1;
   logic        iss_use_rs2;
   logic        iss_use_imm;
   logic        iss_wb_we;
   logic [3:0]  iss_alu_op;
   logic [31:0] iss_imm;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [2:0]  inflight;
   logic [15:0] stall_cycles;
   logic        wb_err;

   int checks;
   int failures;

   issue_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
      .dec_use_imm(dec_use_imm), .dec_wb_we(dec_wb_we),
      .dec_alu_op(dec_alu_op), .dec_imm(dec_imm),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
      .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2),
      .iss_use_imm(iss_use_imm), .iss_wb_we(iss_wb_we),
      .iss_alu_op(iss_alu_op), .iss_imm(iss_imm),
      .wb_valid(wb_valid), .wb_rd(wb_rd),
      .inflight(inflight), .stall_cycles(stall_cycles), .wb_err(wb_err)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Present one decoded instruction and let combinational outputs settle
   task automatic applyStimulus(input logic valid, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic use1, input logic use2,
                                input logic we, input logic [3:0] op, input logic [31:0] imm);
      dec_valid   = valid;
      dec_rd      = rd;
      dec_rs1     = rs1;
      dec_rs2     = rs2;
      dec_use_rs1 = use1;
      dec_use_rs2 = use2;
      dec_use_imm = !use2;
      dec_wb_we   = we;
      dec_alu_op  = op;
      dec_imm     = imm;
      #1;
   endtask

   // Advance one clock and sample registered outputs 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      iss_ready = 1'b1;
      wb_valid  = 1'b0;
      wb_rd     = 5'd0;
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);

      // Reset and idle
      tick();
      checkOutput("ready_in_rst", {31'd0, dec_ready}, 32'd0);
      tick();
      checkOutput("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
      checkOutput("rst_inflight", {29'd0, inflight}, 32'd0);
      checkOutput("rst_stall", {16'd0, stall_cycles}, 32'd0);
      checkOutput("rst_wb_err", {31'd0, wb_err}, 32'd0);
      checkOutput("rst_iss_imm", iss_imm, 32'd0);
      rst = 1'b0;
      tick();
      checkOutput("idle_ready", {31'd0, dec_ready}, 32'd1);
      checkOutput("idle_iss_valid", {31'd0, iss_valid}, 32'd0);

      // RAW stall released by same-cycle writeback
      applyStimulus(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 4'd1, 32'd7);
      checkOutput("addi_ready", {31'd0, dec_ready}, 32'd1);
      tick();
      checkOutput("addi_iss_valid", {31'd0, iss_valid}, 32'd1);
      checkOutput("addi_iss_rd", {27'd0, iss_rd}, 32'd5);
      checkOutput("addi_iss_imm", iss_imm, 32'd7);
      checkOutput("addi_inflight", {29'd0, inflight}, 32'd1);
      applyStimulus(1'b1, 5'd6, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 4'd2, 32'd0);
      checkOutput("raw_stalled", {31'd0, dec_ready}, 32'd0);
      for (int i = 0; i < 3; i++) tick();
      checkOutput("raw_stall_cnt", {16'd0, stall_cycles}, 32'd3);
      wb_valid = 1'b1;
      wb_rd    = 5'd5;
      #1;
      checkOutput("raw_bypass_ready", {31'd0, dec_ready}, 32'd1);
      tick();
      wb_valid = 1'b0;
      checkOutput("raw_iss_rd", {27'd0, iss_rd}, 32'd6);
      checkOutput("raw_iss_op", {28'd0, iss_alu_op}, 32'd2);
      checkOutput("raw_inflight", {29'd0, inflight}, 32'd1);
      checkOutput("raw_stall_hold", {16'd0, stall_cycles}, 32'd3);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
      wb_valid = 1'b1;
      wb_rd    = 5'd6;
      tick();
      wb_valid = 1'b0;
      checkOutput("drain_inflight", {29'd0, inflight}, 32'd0);

      // x0 writes and readers never stall or count as in flight
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'd0, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 4'd3, 32'd0);
         checkOutput("x0_write_ready", {31'd0, dec_ready}, 32'd1);
         tick();
         applyStimulus(1'b1, 5'd8, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 4'd4, 32'd0);
         checkOutput("x0_read_ready", {31'd0, dec_ready}, 32'd1);
         tick();
      end
      checkOutput("x0_inflight", {29'd0, inflight}, 32'd0);
      checkOutput("x0_stall", {16'd0, stall_cycles}, 32'd3);

      // Backpressure holds the slot, then reload in the release cycle
      applyStimulus(1'b1, 5'd10, 5'd11, 5'd0, 1'b1, 1'b0, 1'b0, 4'd9, 32'h1234);
      tick();
      checkOutput("bp_first_imm", iss_imm, 32'h1234);
      iss_ready = 1'b0;
      applyStimulus(1'b1, 5'd12, 5'd13, 5'd0, 1'b1, 1'b0, 1'b0, 4'd10, 32'hBEEF);
      for (int i = 0; i < 4; i++) begin
         checkOutput("bp_ready_low", {31'd0, dec_ready}, 32'd0);
         tick();
         checkOutput("bp_iss_imm_hold", iss_imm, 32'h1234);
         checkOutput("bp_iss_valid", {31'd0, iss_valid}, 32'd1);
      end
      checkOutput("bp_stall", {16'd0, stall_cycles}, 32'd7);
      iss_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", {31'd0, dec_ready}, 32'd1);
      tick();
      checkOutput("bp_reload_imm", iss_imm, 32'hBEEF);
      checkOutput("bp_reload_op", {28'd0, iss_alu_op}, 32'd10);

      // In-flight limit of four writes
      for (int r = 1; r <= 4; r++) begin
         applyStimulus(1'b1, 5'(r), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd5, 32'(r));
         checkOutput("lim_fill_ready", {31'd0, dec_ready}, 32'd1);
         tick();
      end
      checkOutput("lim_inflight4", {29'd0, inflight}, 32'd4);
      applyStimulus(1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd6, 32'd0);
      checkOutput("lim_write_stall", {31'd0, dec_ready}, 32'd0);
      tick();
      applyStimulus(1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd7, 32'd0);
      checkOutput("lim_nowrite_pass", {31'd0, dec_ready}, 32'd1);
      tick();
      applyStimulus(1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd6, 32'd0);
      wb_valid = 1'b1;
      wb_rd    = 5'd2;
      #1;
      checkOutput("lim_wb_release", {31'd0, dec_ready}, 32'd1);
      tick();
      wb_valid = 1'b0;
      checkOutput("lim_inflight_keep", {29'd0, inflight}, 32'd4);
      checkOutput("lim_iss_rd", {27'd0, iss_rd}, 32'd6);
      checkOutput("lim_iss_we", {31'd0, iss_wb_we}, 32'd1);
      checkOutput("lim_stall", {16'd0, stall_cycles}, 32'd8);

      // WAW on pending x3, then writeback error handling
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
      wb_valid = 1'b1;
      wb_rd    = 5'd1;
      tick();
      wb_valid = 1'b0;
      checkOutput("waw_pre_inflight", {29'd0, inflight}, 32'd3);
      applyStimulus(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd8, 32'd0);
      checkOutput("waw_stall", {31'd0, dec_ready}, 32'd0);
      tick();
      tick();
      wb_valid = 1'b1;
      wb_rd    = 5'd3;
      #1;
      checkOutput("waw_release", {31'd0, dec_ready}, 32'd1);
      tick();
      wb_valid = 1'b0;
      checkOutput("waw_inflight", {29'd0, inflight}, 32'd3);
      checkOutput("waw_stall_cnt", {16'd0, stall_cycles}, 32'd10);
      checkOutput("waw_no_err", {31'd0, wb_err}, 32'd0);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
      wb_valid = 1'b1;
      wb_rd    = 5'd7;
      tick();
      wb_valid = 1'b0;
      checkOutput("err_set", {31'd0, wb_err}, 32'd1);
      checkOutput("err_inflight", {29'd0, inflight}, 32'd3);
      tick();
      checkOutput("err_sticky", {31'd0, wb_err}, 32'd1);

      // Mid-operation reset discards state; stale writebacks then flag an error
      rst = 1'b1;
      #1;
      checkOutput("rst2_ready", {31'd0, dec_ready}, 32'd0);
      tick();
      rst = 1'b0;
      checkOutput("rst2_wb_err", {31'd0, wb_err}, 32'd0);
      checkOutput("rst2_inflight", {29'd0, inflight}, 32'd0);
      checkOutput("rst2_iss_valid", {31'd0, iss_valid}, 32'd0);
      checkOutput("rst2_stall", {16'd0, stall_cycles}, 32'd0);
      wb_valid = 1'b1;
      wb_rd    = 5'd4;
      tick();
      wb_valid = 1'b0;
      checkOutput("stale_wb_err", {31'd0, wb_err}, 32'd1);
      checkOutput("stale_inflight", {29'd0, inflight}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
